// File: rtl/issue_read_multi_if.sv
// Instruction bundle handed from the scoreboard to the issue stage, plus the
// per-port consume handshake returned by the issue stage.
interface issue_read_multi_if #(
    parameter int unsigned NR_ISSUE_PORTS = 2,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned VLEN           = 39,
    parameter int unsigned OPW            = 7
);
    localparam int unsigned P = NR_ISSUE_PORTS;

    logic [P-1:0]      instr_valid;
    logic [P-1:0]      instr_ex_valid;
    logic [3*P-1:0]    instr_fu;
    logic [OPW*P-1:0]  instr_op;
    logic [5*P-1:0]    instr_rs1;
    logic [5*P-1:0]    instr_rs2;
    logic [5*P-1:0]    instr_rd;
    logic [P-1:0]      instr_use_imm;
    logic [P-1:0]      instr_use_pc;
    logic [P-1:0]      instr_use_zimm;
    logic [XLEN*P-1:0] instr_imm;
    logic [VLEN*P-1:0] instr_pc;
    logic [P-1:0]      issue_ack;

    modport master (
        output instr_valid, instr_ex_valid, instr_fu, instr_op,
               instr_rs1, instr_rs2, instr_rd,
               instr_use_imm, instr_use_pc, instr_use_zimm,
               instr_imm, instr_pc,
        input  issue_ack
    );

    modport slave (
        input  instr_valid, instr_ex_valid, instr_fu, instr_op,
               instr_rs1, instr_rs2, instr_rd,
               instr_use_imm, instr_use_pc, instr_use_zimm,
               instr_imm, instr_pc,
        output issue_ack
    );
endinterface

// File: rtl/issue_read_multi.sv
// Multi-port operand read / issue stage: RAW and structural hazard checks,
// result forwarding from the scoreboard and a one-cycle registered issue.
module issue_read_multi #(
    parameter int unsigned NR_ISSUE_PORTS = 2,
    parameter int unsigned NR_SB_ENTRIES  = 8,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned VLEN           = 39,
    parameter int unsigned OPW            = 7,
    parameter int unsigned MULT_LATENCY   = 3,
    localparam int unsigned P             = NR_ISSUE_PORTS,
    localparam int unsigned IDXW          = $clog2(NR_SB_ENTRIES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       stall_i,
    issue_read_multi_if.slave          issue,
    output logic                       stall_issue_o,
    output logic [5*P-1:0]             rs1_idx_o,
    output logic [5*P-1:0]             rs2_idx_o,
    input  logic [XLEN*P-1:0]          rs1_data_i,
    input  logic [XLEN*P-1:0]          rs2_data_i,
    input  logic [IDXW-1:0]            sb_issue_ptr_i,
    input  logic [NR_SB_ENTRIES-1:0]   sb_busy_i,
    input  logic [5*NR_SB_ENTRIES-1:0] sb_rd_i,
    input  logic [NR_SB_ENTRIES-1:0]   sb_res_valid_i,
    input  logic [NR_SB_ENTRIES-1:0]   sb_is_csr_i,
    input  logic [XLEN*NR_SB_ENTRIES-1:0] sb_result_i,
    input  logic                       lsu_ready_i,
    input  logic                       flu_ready_i,
    output logic [P-1:0]               alu_valid_o,
    output logic [P-1:0]               branch_valid_o,
    output logic [P-1:0]               lsu_valid_o,
    output logic [P-1:0]               mult_valid_o,
    output logic [P-1:0]               csr_valid_o,
    output logic [XLEN*P-1:0]          operand_a_o,
    output logic [XLEN*P-1:0]          operand_b_o,
    output logic [XLEN*P-1:0]          imm_o,
    output logic [OPW*P-1:0]           op_o,
    output logic [IDXW*P-1:0]          trans_id_o,
    output logic [VLEN*P-1:0]          pc_o
);

    localparam int unsigned CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

    typedef enum logic [2:0] {
        FU_NONE      = 3'd0,
        FU_LOAD      = 3'd1,
        FU_STORE     = 3'd2,
        FU_ALU       = 3'd3,
        FU_CTRL_FLOW = 3'd4,
        FU_MULT      = 3'd5,
        FU_CSR       = 3'd6
    } fu_e;

    typedef struct packed {
        logic            haz;
        logic            fwd;
        logic [XLEN-1:0] data;
    } sb_hit_t;

    fu_e             fu [P];
    logic [P-1:0]    hazard;
    logic [P-1:0]    fu_busy;
    logic [P-1:0]    ack;
    logic [P-1:0]    fwd_a;
    logic [P-1:0]    fwd_b;
    logic [XLEN-1:0] fwd_a_data [P];
    logic [XLEN-1:0] fwd_b_data [P];
    logic            mult_issue;
    logic [CW-1:0]   mult_cnt_q;

    logic [P-1:0]      alu_d, branch_d, lsu_d, mult_d, csr_d;
    logic [XLEN*P-1:0] opa_d, opb_d;

    assign rs1_idx_o       = issue.instr_rs1;
    assign rs2_idx_o       = issue.instr_rs2;
    assign issue.issue_ack = ack;

    // Youngest in-flight producer of rs: walk backward from the entry just
    // before the issue pointer, so the first match is the most recent writer.
    function automatic sb_hit_t sb_lookup(input logic [4:0] rs);
        sb_hit_t             r;
        logic                found;
        logic [IDXW-1:0]     idx;
        r     = '0;
        found = 1'b0;
        idx   = '0;
        if (rs != 5'd0) begin
            for (int unsigned i = 1; i <= NR_SB_ENTRIES; i++) begin
                idx = sb_issue_ptr_i - IDXW'(i);
                if (!found && sb_busy_i[idx] && (sb_rd_i[32'(idx)*5 +: 5] == rs)) begin
                    found  = 1'b1;
                    r.fwd  = sb_res_valid_i[idx] & ~sb_is_csr_i[idx];
                    r.haz  = ~(sb_res_valid_i[idx] & ~sb_is_csr_i[idx]);
                    r.data = sb_result_i[32'(idx)*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    always_comb begin : decode
        for (int unsigned k = 0; k < P; k++) begin
            fu[k] = fu_e'(issue.instr_fu[3*k +: 3]);
        end
    end

    always_comb begin : raw_check
        sb_hit_t    h1, h2;
        logic [4:0] rd_j;
        hazard = '0;
        fwd_a  = '0;
        fwd_b  = '0;
        for (int unsigned k = 0; k < P; k++) begin
            h1            = sb_lookup(issue.instr_rs1[5*k +: 5]);
            h2            = sb_lookup(issue.instr_rs2[5*k +: 5]);
            hazard[k]     = h1.haz | h2.haz;
            fwd_a[k]      = h1.fwd;
            fwd_b[k]      = h2.fwd;
            fwd_a_data[k] = h1.data;
            fwd_b_data[k] = h2.data;
            // Older ports in the same bundle write rd after we read; no bypass.
            for (int unsigned j = 0; j < k; j++) begin
                rd_j = issue.instr_rd[5*j +: 5];
                if (issue.instr_valid[j] && (rd_j != 5'd0) &&
                    ((issue.instr_rs1[5*k +: 5] == rd_j) || (issue.instr_rs2[5*k +: 5] == rd_j))) begin
                    hazard[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin : structural
        logic ls_seen, cm_seen, flu_block;
        ls_seen   = 1'b0;
        cm_seen   = 1'b0;
        flu_block = ~flu_ready_i | (mult_cnt_q != '0);
        fu_busy   = '0;
        for (int unsigned k = 0; k < P; k++) begin
            case (fu[k])
                FU_LOAD, FU_STORE:             fu_busy[k] = ~lsu_ready_i | ls_seen;
                FU_ALU:                        fu_busy[k] = flu_block;
                FU_CTRL_FLOW, FU_MULT, FU_CSR: fu_busy[k] = flu_block | cm_seen;
                default:                       fu_busy[k] = 1'b0;
            endcase
            if (issue.instr_valid[k]) begin
                ls_seen = ls_seen | (fu[k] == FU_LOAD) | (fu[k] == FU_STORE);
                cm_seen = cm_seen | (fu[k] == FU_CTRL_FLOW) | (fu[k] == FU_MULT) | (fu[k] == FU_CSR);
            end
        end
    end

    always_comb begin : ack_chain
        logic prev;
        prev       = ~stall_i & ~flush_i;
        mult_issue = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            ack[k] = prev & issue.instr_valid[k] &
                     (issue.instr_ex_valid[k] | (~hazard[k] & ~fu_busy[k]));
            prev   = ack[k];
            if (ack[k] && !issue.instr_ex_valid[k] && (fu[k] == FU_MULT)) begin
                mult_issue = 1'b1;
            end
        end
        stall_issue_o = |(issue.instr_valid & ~ack);
    end

    always_comb begin : operand_mux
        logic            take;
        logic [VLEN-1:0] pc_k;
        alu_d    = '0;
        branch_d = '0;
        lsu_d    = '0;
        mult_d   = '0;
        csr_d    = '0;
        opa_d    = '0;
        opb_d    = '0;
        for (int unsigned k = 0; k < P; k++) begin
            take        = ack[k] & ~issue.instr_ex_valid[k];
            alu_d[k]    = take & (fu[k] == FU_ALU);
            branch_d[k] = take & (fu[k] == FU_CTRL_FLOW);
            lsu_d[k]    = take & ((fu[k] == FU_LOAD) | (fu[k] == FU_STORE));
            mult_d[k]   = take & (fu[k] == FU_MULT);
            csr_d[k]    = take & (fu[k] == FU_CSR);

            pc_k = issue.instr_pc[VLEN*k +: VLEN];
            if (issue.instr_use_zimm[k])
                opa_d[XLEN*k +: XLEN] = XLEN'(issue.instr_rs1[5*k +: 5]);
            else if (issue.instr_use_pc[k])
                opa_d[XLEN*k +: XLEN] = XLEN'(signed'(pc_k));
            else if (fwd_a[k])
                opa_d[XLEN*k +: XLEN] = fwd_a_data[k];
            else
                opa_d[XLEN*k +: XLEN] = rs1_data_i[XLEN*k +: XLEN];

            // Stores and branches carry the immediate separately; b stays rs2.
            if (issue.instr_use_imm[k] && (fu[k] != FU_STORE) && (fu[k] != FU_CTRL_FLOW))
                opb_d[XLEN*k +: XLEN] = issue.instr_imm[XLEN*k +: XLEN];
            else if (fwd_b[k])
                opb_d[XLEN*k +: XLEN] = fwd_b_data[k];
            else
                opb_d[XLEN*k +: XLEN] = rs2_data_i[XLEN*k +: XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mult_cnt_q <= '0;
        end else if (flush_i) begin
            mult_cnt_q <= '0;
        end else if (mult_issue) begin
            mult_cnt_q <= CW'(MULT_LATENCY - 1);
        end else if (mult_cnt_q != '0) begin
            mult_cnt_q <= mult_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_valid_o    <= '0;
            branch_valid_o <= '0;
            lsu_valid_o    <= '0;
            mult_valid_o   <= '0;
            csr_valid_o    <= '0;
            operand_a_o    <= '0;
            operand_b_o    <= '0;
            imm_o          <= '0;
            op_o           <= '0;
            trans_id_o     <= '0;
            pc_o           <= '0;
        end else begin
            alu_valid_o    <= alu_d;
            branch_valid_o <= branch_d;
            lsu_valid_o    <= lsu_d;
            mult_valid_o   <= mult_d;
            csr_valid_o    <= csr_d;
            operand_a_o    <= opa_d;
            operand_b_o    <= opb_d;
            imm_o          <= issue.instr_imm;
            op_o           <= issue.instr_op;
            pc_o           <= issue.instr_pc;
            for (int unsigned k = 0; k < P; k++) begin
                trans_id_o[IDXW*k +: IDXW] <= sb_issue_ptr_i + IDXW'(k);
            end
        end
    end

endmodule

// File: tb/tb_issue_read_multi.sv
// Randomised scoreboard bench for issue_read_multi with a behavioural model of
// the issue rules; expectations are queued per cycle and checked by a monitor.
module tb_issue_read_multi;
    localparam int unsigned P    = 2;
    localparam int unsigned N    = 8;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 39;
    localparam int unsigned OPW  = 7;
    localparam int unsigned LAT  = 3;
    localparam int unsigned IDXW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, stall, lsu_ready, flu_ready;
    logic [P-1:0]      valid, ex, use_imm, use_pc, use_zimm;
    logic [3*P-1:0]    fu;
    logic [OPW*P-1:0]  op;
    logic [5*P-1:0]    rs1, rs2, rd;
    logic [XLEN*P-1:0] imm, rs1_data, rs2_data;
    logic [VLEN*P-1:0] pc;
    logic [IDXW-1:0]   sb_ptr;
    logic [N-1:0]      sb_busy, sb_resv, sb_csr;
    logic [5*N-1:0]    sb_rd;
    logic [XLEN*N-1:0] sb_result;

    logic              stall_issue;
    logic [5*P-1:0]    rs1_idx, rs2_idx;
    logic [P-1:0]      alu_v, br_v, lsu_v, mul_v, csr_v;
    logic [XLEN*P-1:0] opa, opb, imm_q;
    logic [OPW*P-1:0]  op_q;
    logic [IDXW*P-1:0] tid;
    logic [VLEN*P-1:0] pc_q;

    issue_read_multi_if #(.NR_ISSUE_PORTS(P), .XLEN(XLEN), .VLEN(VLEN), .OPW(OPW)) ifc ();
    assign ifc.instr_valid    = valid;
    assign ifc.instr_ex_valid = ex;
    assign ifc.instr_fu       = fu;
    assign ifc.instr_op       = op;
    assign ifc.instr_rs1      = rs1;
    assign ifc.instr_rs2      = rs2;
    assign ifc.instr_rd       = rd;
    assign ifc.instr_use_imm  = use_imm;
    assign ifc.instr_use_pc   = use_pc;
    assign ifc.instr_use_zimm = use_zimm;
    assign ifc.instr_imm      = imm;
    assign ifc.instr_pc       = pc;

    issue_read_multi #(
        .NR_ISSUE_PORTS(P), .NR_SB_ENTRIES(N), .XLEN(XLEN),
        .VLEN(VLEN), .OPW(OPW), .MULT_LATENCY(LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
        .issue(ifc.slave), .stall_issue_o(stall_issue),
        .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .sb_issue_ptr_i(sb_ptr), .sb_busy_i(sb_busy), .sb_rd_i(sb_rd),
        .sb_res_valid_i(sb_resv), .sb_is_csr_i(sb_csr), .sb_result_i(sb_result),
        .lsu_ready_i(lsu_ready), .flu_ready_i(flu_ready),
        .alu_valid_o(alu_v), .branch_valid_o(br_v), .lsu_valid_o(lsu_v),
        .mult_valid_o(mul_v), .csr_valid_o(csr_v),
        .operand_a_o(opa), .operand_b_o(opb), .imm_o(imm_q),
        .op_o(op_q), .trans_id_o(tid), .pc_o(pc_q)
    );

    typedef struct packed {
        logic              rst;
        logic [P-1:0]      ack;
        logic              stall_issue;
        logic [10*P-1:0]   rsidx;
        logic [P-1:0]      alu, br, lsu, mul, csr;
        logic [XLEN*P-1:0] opa, opb, imm;
        logic [OPW*P-1:0]  op;
        logic [IDXW*P-1:0] tid;
        logic [VLEN*P-1:0] pc;
    } exp_t;

    exp_t        q[$];
    int unsigned mcnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Entry number of the most recent in-flight writer of r, or -1.
    function automatic int youngest(input logic [4:0] r);
        int e;
        if (r == 5'd0) return -1;
        for (int age = 1; age <= int'(N); age++) begin
            e = (int'(sb_ptr) + int'(N) - age) % int'(N);
            if (sb_busy[e] && sb_rd[5*e +: 5] == r) return e;
        end
        return -1;
    endfunction

    function automatic exp_t model_cycle();
        exp_t            e;
        int              pa, pb;
        int unsigned     ls_cnt, cm_cnt, f;
        logic            chain, raw, busy, go, rdy_a, rdy_b, ls, cm, flu, mult_go;
        logic [4:0]      a, b, d;
        logic [VLEN-1:0] pcv;
        logic [63:0]     sx;
        e = '0;
        e.rst = !rst_n;
        if (!rst_n) mcnt = 0;
        e.rsidx = {rs2, rs1};
        chain = !stall && !flush;
        ls_cnt = 0; cm_cnt = 0; mult_go = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            f = int'(fu[3*k +: 3]);
            a = rs1[5*k +: 5];
            b = rs2[5*k +: 5];
            pa = youngest(a);
            pb = youngest(b);
            rdy_a = (pa >= 0) && sb_resv[pa] && !sb_csr[pa];
            rdy_b = (pb >= 0) && sb_resv[pb] && !sb_csr[pb];
            raw = ((pa >= 0) && !rdy_a) || ((pb >= 0) && !rdy_b);
            for (int unsigned j = 0; j < k; j++) begin
                d = rd[5*j +: 5];
                if (valid[j] && ((a != 0 && a == d) || (b != 0 && b == d))) raw = 1'b1;
            end
            ls  = (f == 1) || (f == 2);
            cm  = (f == 4) || (f == 5) || (f == 6);
            flu = cm || (f == 3);
            busy = (ls && (!lsu_ready || ls_cnt > 0)) ||
                   (flu && (!flu_ready || mcnt != 0)) ||
                   (cm && cm_cnt > 0);
            if (valid[k]) begin
                if (ls) ls_cnt++;
                if (cm) cm_cnt++;
            end
            go = valid[k] && chain && (ex[k] || (!raw && !busy));
            e.ack[k] = go;
            chain = go;
            if (valid[k] && !go) e.stall_issue = 1'b1;
            if (go && !ex[k] && f == 5) mult_go = 1'b1;
            if (rst_n) begin
                if (go && !ex[k]) begin
                    e.alu[k] = (f == 3);
                    e.br[k]  = (f == 4);
                    e.lsu[k] = ls;
                    e.mul[k] = (f == 5);
                    e.csr[k] = (f == 6);
                end
                pcv = pc[VLEN*k +: VLEN];
                sx  = 64'(pcv);
                if (pcv[VLEN-1]) sx = sx | ~((64'd1 << VLEN) - 64'd1);
                if (use_zimm[k])      e.opa[XLEN*k +: XLEN] = 64'(a);
                else if (use_pc[k])   e.opa[XLEN*k +: XLEN] = sx;
                else if (rdy_a)       e.opa[XLEN*k +: XLEN] = sb_result[XLEN*pa +: XLEN];
                else                  e.opa[XLEN*k +: XLEN] = rs1_data[XLEN*k +: XLEN];
                if (use_imm[k] && f != 2 && f != 4) e.opb[XLEN*k +: XLEN] = imm[XLEN*k +: XLEN];
                else if (rdy_b)                     e.opb[XLEN*k +: XLEN] = sb_result[XLEN*pb +: XLEN];
                else                                e.opb[XLEN*k +: XLEN] = rs2_data[XLEN*k +: XLEN];
                e.tid[IDXW*k +: IDXW] = IDXW'((int'(sb_ptr) + int'(k)) % int'(N));
            end
        end
        if (rst_n) begin
            e.imm = imm;
            e.op  = op;
            e.pc  = pc;
        end
        if (!rst_n || flush) mcnt = 0;
        else if (mult_go)    mcnt = LAT - 1;
        else if (mcnt != 0)  mcnt = mcnt - 1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_regs(input exp_t r);
        chk("strobes", {alu_v, br_v, lsu_v, mul_v, csr_v}, {r.alu, r.br, r.lsu, r.mul, r.csr});
        chk("operand_a", opa, r.opa);
        chk("operand_b", opb, r.opb);
        chk("imm", imm_q, r.imm);
        chk("op", op_q, r.op);
        chk("trans_id", tid, r.tid);
        chk("pc", pc_q, r.pc);
    endtask

    initial begin : monitor
        exp_t cur, prev;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                cur = q.pop_front();
                if (cur.rst) check_regs('0);
                else if (have_prev) check_regs(prev);
                chk("ack", ifc.issue_ack, cur.ack);
                chk("stall_issue", stall_issue, cur.stall_issue);
                chk("rs_idx", {rs2_idx, rs1_idx}, cur.rsidx);
                prev = cur;
                have_prev = 1'b1;
            end
        end
    end

    task automatic idle();
        valid = '0; ex = '0; use_imm = '0; use_pc = '0; use_zimm = '0;
        fu = '0; op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0; pc = '0;
        rs1_data = {$urandom, $urandom, $urandom, $urandom};
        rs2_data = {$urandom, $urandom, $urandom, $urandom};
        sb_ptr = '0; sb_busy = '0; sb_resv = '0; sb_csr = '0; sb_rd = '0;
        for (int i = 0; i < int'(N); i++) sb_result[XLEN*i +: XLEN] = {$urandom, $urandom};
        flush = 1'b0; stall = 1'b0; lsu_ready = 1'b1; flu_ready = 1'b1;
    endtask

    task automatic set_port(input int k, input int f, input int a, input int b, input int d);
        valid[k] = 1'b1;
        fu[3*k +: 3]      = 3'(f);
        rs1[5*k +: 5]     = 5'(a);
        rs2[5*k +: 5]     = 5'(b);
        rd[5*k +: 5]      = 5'(d);
        op[OPW*k +: OPW]  = OPW'($urandom);
        imm[XLEN*k +: XLEN] = {$urandom, $urandom};
        pc[VLEN*k +: VLEN]  = VLEN'({$urandom, $urandom});
    endtask

    task automatic rand_cycle();
        rst_n     = ($urandom_range(0, 99) != 0);
        flush     = ($urandom_range(0, 19) == 0);
        stall     = ($urandom_range(0, 11) == 0);
        lsu_ready = ($urandom_range(0, 7) != 0);
        flu_ready = ($urandom_range(0, 7) != 0);
        sb_ptr    = IDXW'($urandom);
        sb_busy   = N'($urandom);
        sb_resv   = N'($urandom);
        sb_csr    = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
        for (int i = 0; i < int'(N); i++) begin
            sb_rd[5*i +: 5] = 5'($urandom_range(0, 7));
            sb_result[XLEN*i +: XLEN] = {$urandom, $urandom};
        end
        rs1_data = {$urandom, $urandom, $urandom, $urandom};
        rs2_data = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < int'(P); k++) begin
            valid[k]    = ($urandom_range(0, 7) != 0);
            ex[k]       = ($urandom_range(0, 9) == 0);
            use_imm[k]  = ($urandom_range(0, 3) == 0);
            use_pc[k]   = ($urandom_range(0, 3) == 0);
            use_zimm[k] = ($urandom_range(0, 3) == 0);
            fu[3*k +: 3]  = 3'($urandom_range(0, 6));
            rs1[5*k +: 5] = 5'($urandom_range(0, 7));
            rs2[5*k +: 5] = 5'($urandom_range(0, 7));
            rd[5*k +: 5]  = 5'($urandom_range(0, 7));
            op[OPW*k +: OPW]    = OPW'($urandom);
            imm[XLEN*k +: XLEN] = {$urandom, $urandom};
            pc[VLEN*k +: VLEN]  = VLEN'({$urandom, $urandom});
        end
    endtask

    task automatic step();
        q.push_back(model_cycle());
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step(); step();
        rst_n = 1'b1;

        idle(); sb_ptr = 3'd3; set_port(0, 3, 1, 2, 3); set_port(1, 3, 4, 0, 5); step();
        idle(); set_port(0, 3, 1, 2, 3); set_port(1, 3, 3, 0, 6); step();
        idle(); set_port(0, 3, 3, 0, 6); step();

        idle(); sb_busy[6] = 1'b1; sb_rd[30 +: 5] = 5'd7; sb_resv[6] = 1'b1;
        sb_result[6*XLEN +: XLEN] = 64'hDEAD; set_port(0, 3, 7, 0, 8); step();
        sb_resv[6] = 1'b0; step();
        sb_resv[6] = 1'b1; sb_csr[6] = 1'b1; step();

        idle(); sb_ptr = 3'd2;
        sb_busy[6] = 1'b1; sb_rd[30 +: 5] = 5'd7; sb_resv[6] = 1'b1; sb_result[6*XLEN +: XLEN] = 64'h6666;
        sb_busy[1] = 1'b1; sb_rd[5 +: 5]  = 5'd7; sb_resv[1] = 1'b1; sb_result[1*XLEN +: XLEN] = 64'h1111;
        set_port(0, 3, 7, 7, 8); step();

        idle(); set_port(0, 5, 1, 2, 3); step();
        repeat (3) begin idle(); set_port(0, 3, 1, 2, 4); step(); end
        idle(); set_port(0, 5, 1, 2, 3); step();
        idle(); set_port(0, 3, 1, 2, 4); step();
        idle(); set_port(0, 3, 1, 2, 4); flush = 1'b1; step();
        idle(); set_port(0, 3, 1, 2, 4); step();

        idle(); set_port(0, 1, 1, 2, 3); set_port(1, 1, 4, 5, 6); step();
        idle(); set_port(0, 3, 1, 2, 3); set_port(1, 3, 4, 5, 6); flush = 1'b1; step();
        idle(); set_port(0, 3, 1, 2, 3); set_port(1, 3, 4, 5, 6); use_pc = 2'b01; use_zimm = 2'b10; step();
        idle(); set_port(0, 3, 1, 2, 3); set_port(1, 3, 4, 5, 6); rst_n = 1'b0; step();
        rst_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            rand_cycle();
            step();
        end

        rst_n = 1'b1;
        idle(); step();
        idle(); step();
        repeat (2) @(negedge clk);
        #1;
        chk("drain", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
